// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection and operand forwarding for the in-order pipeline.
// A shift register tracks every in-flight destination from EX (stage 0) to
// WB (stage DEPTH-1). ID is stalled while a hitting producer is too young to
// forward; the EX instruction's operands take the youngest matching producer.
module pipe_hazard_ctrl #(
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned DEPTH    = 3,
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned CNT_W    = 16,
   localparam int unsigned FSEL_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              flush_ex,
   output logic              stall,
   output logic              pc_write,
   output logic [FSEL_W-1:0] fwd_sel_a,
   output logic [FSEL_W-1:0] fwd_sel_b,
   output logic [CNT_W-1:0]  stall_cnt
);

   // Tracker state, one bit/field per stage
   logic [DEPTH-1:0]  vld_q, vld_d;
   logic [DEPTH-1:0]  wr_q, wr_d;
   logic [DEPTH-1:0]  ld_q, ld_d;
   logic [REG_AW-1:0] rd_q [DEPTH];
   logic [REG_AW-1:0] rd_d [DEPTH];

   // Source operands of the instruction in EX
   logic [REG_AW-1:0] ex_rs_q, ex_rs_d;
   logic [REG_AW-1:0] ex_rt_q, ex_rt_d;
   logic              ex_use_rs_q, ex_use_rs_d;
   logic              ex_use_rt_q, ex_use_rt_d;

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              stall_raw;
   logic              issue;

   // Load-use detection: a hit stalls while its producer is not yet forwardable
   always_comb begin
      stall_raw = 1'b0;
      for (int k = 0; k < int'(DEPTH); k++) begin
         logic hit_rs;
         logic hit_rt;
         int   ready;
         hit_rs = id_use_rs && (id_rs != '0) && (rd_q[k] == id_rs);
         hit_rt = id_use_rt && (id_rt != '0) && (rd_q[k] == id_rt);
         ready  = ld_q[k] ? (1 + int'(LOAD_LAT)) : 1;
         if (id_valid && vld_q[k] && wr_q[k] && (hit_rs || hit_rt) && ((k + 1) < ready)) begin
            stall_raw = 1'b1;
         end
      end
      // A flushed EX slot must not hold up the front end
      stall    = stall_raw & ~flush_ex;
      pc_write = ~stall;
   end

   // Forward selects: scan oldest to youngest so the lowest stage wins
   always_comb begin
      fwd_sel_a = '0;
      fwd_sel_b = '0;
      for (int k = int'(DEPTH) - 1; k >= 1; k--) begin
         if (vld_q[k] && wr_q[k]) begin
            if (ex_use_rs_q && (ex_rs_q != '0) && (rd_q[k] == ex_rs_q)) begin
               fwd_sel_a = FSEL_W'(k);
            end
            if (ex_use_rt_q && (ex_rt_q != '0) && (rd_q[k] == ex_rt_q)) begin
               fwd_sel_b = FSEL_W'(k);
            end
         end
      end
   end

   // Tracker shift and saturating stall counter next state
   always_comb begin
      issue = id_valid & ~stall & ~flush_ex;

      vld_d[0] = issue;
      wr_d[0]  = id_reg_write;
      ld_d[0]  = id_mem_read;
      rd_d[0]  = id_rd;
      for (int k = 1; k < int'(DEPTH); k++) begin
         vld_d[k] = vld_q[k-1];
         wr_d[k]  = wr_q[k-1];
         ld_d[k]  = ld_q[k-1];
         rd_d[k]  = rd_q[k-1];
      end
      // Killed EX instruction travels on as a bubble
      vld_d[1] = vld_q[0] & ~flush_ex;

      ex_rs_d     = id_rs;
      ex_rt_d     = id_rt;
      ex_use_rs_d = issue & id_use_rs;
      ex_use_rt_d = issue & id_use_rt;

      cnt_d = cnt_q;
      if (stall && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign stall_cnt = cnt_q;

   // State registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q       <= '0;
         wr_q        <= '0;
         ld_q        <= '0;
         for (int k = 0; k < int'(DEPTH); k++) begin
            rd_q[k] <= '0;
         end
         ex_rs_q     <= '0;
         ex_rt_q     <= '0;
         ex_use_rs_q <= 1'b0;
         ex_use_rt_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         vld_q       <= vld_d;
         wr_q        <= wr_d;
         ld_q        <= ld_d;
         for (int k = 0; k < int'(DEPTH); k++) begin
            rd_q[k] <= rd_d[k];
         end
         ex_rs_q     <= ex_rs_d;
         ex_rt_q     <= ex_rt_d;
         ex_use_rs_q <= ex_use_rs_d;
         ex_use_rt_q <= ex_use_rt_d;
         cnt_q       <= cnt_d;
      end
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard-detection and forwarding controller for the in-order MIPS-style pipeline. It replaces the fixed two-source forwarding unit and single-cycle load-use detector. It tracks every in-flight destination register from EX through WB in an internal shift register, and produces three things:
- ID-stage stall for load-use and multi-cycle-load hazards
- EX-stage operand forward selects from any later stage
- a saturating stall-cycle counter

Branch flush of the EX instruction is supported.

## Interface
- REG_AW, 5, register address width
- DEPTH, 3, tracked stages after ID (stage 0 = EX … stage DEPTH-1 = WB); DEPTH ≥ 3
- LOAD_LAT, 1, stages after EX before load data is forwardable; 1 ≤ LOAD_LAT ≤ DEPTH-2
- CNT_W, 16, stall counter width
- FSEL_W, $clog2(DEPTH), forward-select width (derived, not overridable)

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  valid instruction in IF/ID
- id_rs, id_rt  in  REG_AW  source register addresses in ID
- id_use_rs, id_use_rt  in  1  operand actually read
- id_rd  in  REG_AW  destination register of ID instruction
- id_reg_write  in  1  ID instruction writes the register file
- id_mem_read  in  1  ID instruction is a load
- flush_ex  in  1  kill instruction currently in EX (branch taken)
- stall  out  1  hold PC and IF/ID, insert bubble into EX
- pc_write  out  1  equals ~stall
- fwd_sel_a, fwd_sel_b  out  FSEL_W  EX operand source: 0 = ID/EX register value, k = result of stage k
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- Tracker: DEPTH entries {valid, rd, reg_write, is_load}. Each EX entry also holds the issuing instruction's rs, rt, use_rs and use_rt.
- Ready stage per entry:
  - non-load: 1
  - load: 1 + LOAD_LAT
- Entry k "hits" ID operand X when all of the following hold: valid, reg_write, rd == X, X != 0, use_X, id_valid.
- stall = 1 when any entry k hits and k + 1 < ready stage of that entry. Otherwise stall = 0.
  - With DEPTH=3 and LOAD_LAT=1 this is exactly the classic load-in-EX case.
- Forwarding for the EX instruction (entry 0 operands):
  - Candidate stages are k = 1 … DEPTH-1 where the entry is valid, reg_write, rd == operand, operand != 0, and use bit set.
  - The lowest k (youngest producer) wins.
  - No match gives 0.
- Shift every cycle, never held:
  - entry k+1 ← entry k
  - entry 0 ← ID instruction if id_valid & ~stall & ~flush_ex, else bubble (valid=0)
- flush_ex:
  - Entry 0 moves to stage 1 with valid cleared.
  - Issue is blocked that cycle.
  - flush_ex has priority over stall, and stall is forced to 0 while flush_ex = 1.
- stall_cnt increments on each cycle with stall = 1 and saturates at 2^CNT_W - 1. No wrap.
- Register 0 never creates a stall or a forward.

## Timing
- stall, pc_write, fwd_sel_a and fwd_sel_b are combinational from tracker state and ID inputs. There are no registered outputs apart from stall_cnt.
- An ID instruction accepted at edge N occupies stage k after edge N+k. Its entry is dropped after stage DEPTH-1.
- For the stall duration in a load-use case: a load issued at edge N stalls a dependent ID instruction for LOAD_LAT cycles. The dependent instruction issues on the following edge and sees fwd_sel = 1 + LOAD_LAT.
- Reset state:
  - all tracker valid bits = 0
  - stall = 0, pc_write = 1
  - fwd_sel_a = fwd_sel_b = 0
  - stall_cnt = 0
- Reset asserted mid-stall clears all state immediately. The first edge after deassertion behaves as an empty pipeline.
- Simultaneous hits on rs and rt produce one stall, not two. Each operand's forward select is resolved independently.

## Test plan
- ALU back-to-back, defaults: add $3 ← $1,$2 then sub $4 ← $3,$5 -> no stall; the sub in EX sees fwd_sel_a=1, fwd_sel_b=0.
- Load-use, defaults: lw $2 then add $6 ← $2,$2 -> stall=1 for exactly 1 cycle, stall_cnt=1; the add in EX sees fwd_sel_a=fwd_sel_b=2.
- LOAD_LAT=2, DEPTH=4: lw $7 then an instruction using $7 -> 2 stall cycles, then fwd_sel=3.
- Youngest wins: writes to $9 issued in consecutive cycles, then a reader of $9 -> fwd_sel=1, not 2. A write to $0 followed by a reader of $0 -> no stall, fwd_sel=0.
- Flush over stall: lw $2 in EX with flush_ex=1 while ID reads $2 -> stall=0. On the next edge entry 1 is invalid, so a reader of $2 entering EX later sees fwd_sel=0.
- Counter saturation with CNT_W=2: force 5 stall cycles -> stall_cnt sequence 1,2,3,3,3. Assert rst mid-stall -> stall=0, stall_cnt=0, pc_write=1 immediately.
